noc_leaf_port: RTL and testbench

Router-side leaf port for a single GPU network interface (NI). It is the other end of the NI's router interface.
- Ingress: accepts header-translated flits from the NI and decodes the 6-bit routing header (4-bit group, 2-bit leaf).
- Forwarding: flits for the local GPU loop back to the ejection path; all other valid flits go up to the group switch.
- Egress: flits arriving from the group switch are checked against the local address, then ejected to the NI.

---
 rtl/noc_pkg.sv | 22 ++
 rtl/noc_leaf_port_if.sv | 32 +++
 rtl/noc_flit_fifo.sv | 53 +++++
 rtl/noc_leaf_port.sv | 123 ++++++++++++
 tb/tb_noc_leaf_port.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit/header geometry and GPU <-> router address mapping.
package noc_pkg;

    localparam int DATA_W   = 16;
    localparam int HEADER_W = 6;
    localparam int GROUP_W  = 4;
    localparam int LEAF_W   = 2;

    localparam logic [HEADER_W-1:0] ADDR_INVALID = 6'b000000;

    // GPU ids 1..32 map to router addresses 4..35; anything else is unroutable.
    function automatic logic [HEADER_W-1:0] gpu_to_addr(input int unsigned id);
        if (id >= 1 && id <= 32) return HEADER_W'(id + 3);
        return ADDR_INVALID;
    endfunction

    function automatic int unsigned addr_to_gpu(input logic [HEADER_W-1:0] addr);
        if (addr >= 6'd4 && addr <= 6'd35) return 32'(addr) - 32'd3;
        return 0;
    endfunction

endpackage

// File: rtl/noc_leaf_port_if.sv
// NI-side and group-switch-side signals of one leaf port.
interface noc_leaf_port_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] ni_data_in;
    logic              ni_valid_in;
    logic              ni_ready_out;
    logic [DATA_W-1:0] ni_data_out;
    logic              ni_valid_out;
    logic [DATA_W-1:0] up_data_out;
    logic              up_valid_out;
    logic              up_ready_in;
    logic [DATA_W-1:0] up_data_in;
    logic              up_valid_in;
    logic              up_ready_out;
    logic [7:0]        drop_count;
    logic              err_overflow;

    // Environment side: NI plus group switch.
    modport master (
        output ni_data_in, ni_valid_in, up_ready_in, up_data_in, up_valid_in,
        input  ni_ready_out, ni_data_out, ni_valid_out, up_data_out, up_valid_out,
        input  up_ready_out, drop_count, err_overflow
    );

    // Leaf port side.
    modport slave (
        input  ni_data_in, ni_valid_in, up_ready_in, up_data_in, up_valid_in,
        output ni_ready_out, ni_data_out, ni_valid_out, up_data_out, up_valid_out,
        output up_ready_out, drop_count, err_overflow
    );
endinterface

// File: rtl/noc_flit_fifo.sv
// Show-ahead synchronous FIFO; the head entry is always visible on o_data.
module noc_flit_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // Ignore pushes when full and pops when empty.
    always_comb begin
        w_push = i_push && (int'(r_count) < DEPTH);
        w_pop  = i_pop && (r_count != '0);
    end

    // Storage array, data only: no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers wrap naturally at the power-of-two depth; count disambiguates full/empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/noc_leaf_port.sv
// Router leaf port: NI ingress with header decode, uplink register, eject arbitration.
module noc_leaf_port #(
    parameter int         DATA_W     = 16,
    parameter int         HEADER_W   = 6,
    parameter logic [3:0] GROUP_ID   = 4'd5,
    parameter logic [1:0] LEAF_ID    = 2'd0,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    noc_leaf_port_if.slave bus
);
    import noc_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [HEADER_W-1:0] LOCAL = {GROUP_ID, LEAF_ID};

    function automatic logic [HEADER_W-1:0] hdr_of(input logic [DATA_W-1:0] f);
        return f[DATA_W-1 -: HEADER_W];
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    logic [DATA_W-1:0] w_in_head, w_ej_head;
    logic [CW-1:0]     w_in_count, w_ej_count;
    logic              w_in_empty, w_in_full, w_ej_empty, w_ej_full;
    logic              w_ni_ready, w_up_ready, w_in_push, w_in_pop, w_ej_push, w_ej_pop;
    logic              w_dn_acc, w_drop_ovf, w_drop_mis;
    logic              w_head_lb, w_head_up, w_head_inv, w_load_ok, w_gnt_dn, w_gnt_lb;
    logic [1:0]        w_drops;

    logic              r_inflight, r_prio, r_err_ovf;
    logic [7:0]        r_drop_count;
    logic              r_up_vld_p1, r_ej_vld_p1;
    logic [DATA_W-1:0] r_up_data_p1, r_ej_data_p1;

    noc_flit_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_ingress (
        .clk(clk), .rst_n(reset), .i_push(w_in_push), .i_data(bus.ni_data_in),
        .i_pop(w_in_pop), .o_data(w_in_head), .o_count(w_in_count)
    );

    noc_flit_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_eject (
        .clk(clk), .rst_n(reset), .i_push(w_ej_push), .i_data(bus.up_data_in),
        .i_pop(w_ej_pop), .o_data(w_ej_head), .o_count(w_ej_count)
    );

    // Flow control, head decode, eject arbitration and drop accounting.
    always_comb begin
        w_in_empty = (w_in_count == '0);
        w_in_full  = (int'(w_in_count) == FIFO_DEPTH);
        w_ej_empty = (w_ej_count == '0);
        w_ej_full  = (int'(w_ej_count) == FIFO_DEPTH);
        // Reserve a slot for the flit the NI may send in answer to last cycle's ready.
        w_ni_ready = reset && ((int'(w_in_count) + int'(r_inflight)) < FIFO_DEPTH);
        w_up_ready = reset && !w_ej_full;
        w_in_push  = bus.ni_valid_in && !w_in_full;
        w_drop_ovf = bus.ni_valid_in && w_in_full;
        w_head_inv = !w_in_empty && (hdr_of(w_in_head) == ADDR_INVALID);
        w_head_lb  = !w_in_empty && (hdr_of(w_in_head) == LOCAL);
        w_head_up  = !w_in_empty && !w_head_inv && !w_head_lb;
        w_load_ok  = !r_up_vld_p1 || bus.up_ready_in;
        // r_prio == 0 favours the downlink side.
        w_gnt_dn   = !w_ej_empty && (!w_head_lb || !r_prio);
        w_gnt_lb   = w_head_lb && !w_gnt_dn;
        w_in_pop   = w_head_inv || w_gnt_lb || (w_head_up && w_load_ok);
        w_ej_pop   = w_gnt_dn;
        w_dn_acc   = bus.up_valid_in && w_up_ready;
        w_ej_push  = w_dn_acc && (hdr_of(bus.up_data_in) == LOCAL);
        w_drop_mis = w_dn_acc && (hdr_of(bus.up_data_in) != LOCAL);
        w_drops    = {1'b0, w_drop_ovf} + {1'b0, w_head_inv} + {1'b0, w_drop_mis};
    end

    // Control state: inflight slot, arbiter priority, error/drop statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inflight   <= 1'b0;
            r_prio       <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_drop_count <= 8'd0;
        end else begin
            r_inflight   <= w_ni_ready;
            if (w_head_lb && !w_ej_empty) r_prio <= ~r_prio;
            if (w_drop_ovf) r_err_ovf <= 1'b1;
            r_drop_count <= sat_add(r_drop_count, w_drops);
        end
    end

    // Stage p1, uplink: reload whenever the register is empty or being drained.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_up_vld_p1  <= 1'b0;
            r_up_data_p1 <= '0;
        end else if (w_load_ok) begin
            r_up_vld_p1 <= w_head_up;
            if (w_head_up) r_up_data_p1 <= w_in_head;
        end
    end

    // Stage p1, eject: one-cycle pulse carrying the granted flit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ej_vld_p1  <= 1'b0;
            r_ej_data_p1 <= '0;
        end else begin
            r_ej_vld_p1 <= w_gnt_dn || w_gnt_lb;
            if (w_gnt_dn)      r_ej_data_p1 <= w_ej_head;
            else if (w_gnt_lb) r_ej_data_p1 <= w_in_head;
        end
    end

    assign bus.ni_ready_out = w_ni_ready;
    assign bus.up_ready_out = w_up_ready;
    assign bus.up_valid_out = r_up_vld_p1;
    assign bus.up_data_out  = r_up_data_p1;
    assign bus.ni_valid_out = r_ej_vld_p1;
    assign bus.ni_data_out  = r_ej_data_p1;
    assign bus.drop_count   = r_drop_count;
    assign bus.err_overflow = r_err_ovf;
endmodule

// File: tb/tb_noc_leaf_port.sv
// Directed bench for noc_leaf_port: single-flit vector table plus multi-cycle sequences.
module tb_noc_leaf_port;

    logic clk;
    logic reset;

    noc_leaf_port_if #(.DATA_W(16)) bus ();

    noc_leaf_port dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        from_dn;
        logic [15:0] data;
        int          exp_ej;
        int          exp_up;
        int          exp_drop;
    } vec_t;

    vec_t vecs [9];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] ni_q [$];
    logic [15:0] dn_q [$];
    logic [15:0] ej_log [$];
    int          ej_cyc [$];
    logic [15:0] up_log [$];
    int          up_cyc [$];
    logic        ni_prev_ready = 1'b0;
    int          ni_send_cyc = 0;
    int          dn_send_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic clear_logs();
        ej_log.delete(); ej_cyc.delete(); up_log.delete(); up_cyc.delete();
    endtask

    // One clock cycle, entered and left at a falling edge. NI sends one cycle after ready.
    task automatic step();
        logic dn_acc;
        if (ni_prev_ready && ni_q.size() > 0) begin
            bus.ni_valid_in = 1'b1;
            bus.ni_data_in  = ni_q.pop_front();
            ni_send_cyc     = cyc + 1;
        end else begin
            bus.ni_valid_in = 1'b0;
            bus.ni_data_in  = '0;
        end
        ni_prev_ready = bus.ni_ready_out;
        if (dn_q.size() > 0) begin
            bus.up_valid_in = 1'b1;
            bus.up_data_in  = dn_q[0];
        end else begin
            bus.up_valid_in = 1'b0;
            bus.up_data_in  = '0;
        end
        dn_acc = bus.up_valid_in && bus.up_ready_out;
        if (dn_acc) dn_send_cyc = cyc + 1;
        if (bus.up_valid_out && bus.up_ready_in) begin
            up_log.push_back(bus.up_data_out);
            up_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        if (dn_acc) void'(dn_q.pop_front());
        @(negedge clk);
        if (bus.ni_valid_out) begin
            ej_log.push_back(bus.ni_data_out);
            ej_cyc.push_back(cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ni_valid_out"}, 32'(bus.ni_valid_out), 0);
        chk({tag, "_ni_data_out"},  32'(bus.ni_data_out),  0);
        chk({tag, "_up_valid_out"}, 32'(bus.up_valid_out), 0);
        chk({tag, "_up_data_out"},  32'(bus.up_data_out),  0);
        chk({tag, "_ni_ready_out"}, 32'(bus.ni_ready_out), 0);
        chk({tag, "_up_ready_out"}, 32'(bus.up_ready_out), 0);
        chk({tag, "_drop_count"},   32'(bus.drop_count),   0);
        chk({tag, "_err_overflow"}, 32'(bus.err_overflow), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int rel;
        bit found;

        vecs[0] = '{1'b0, 16'h5123, 1, 0, 0};
        vecs[1] = '{1'b0, 16'h12AB, 0, 1, 0};
        vecs[2] = '{1'b0, 16'h0007, 0, 0, 1};
        vecs[3] = '{1'b1, 16'h53FF, 1, 0, 0};
        vecs[4] = '{1'b1, 16'h1000, 0, 0, 1};
        vecs[5] = '{1'b0, 16'hFC01, 0, 1, 0};
        vecs[6] = '{1'b0, 16'h5000, 1, 0, 0};
        vecs[7] = '{1'b1, 16'h5001, 1, 0, 0};
        vecs[8] = '{1'b1, 16'h0000, 0, 0, 1};

        reset           = 1'b0;
        bus.ni_data_in  = '0;
        bus.ni_valid_in = 1'b0;
        bus.up_ready_in = 1'b0;
        bus.up_data_in  = '0;
        bus.up_valid_in = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_all_zero("rst");
        reset = 1'b1;
        step();
        chk("post_rst_ni_ready", 32'(bus.ni_ready_out), 1);
        chk("post_rst_up_ready", 32'(bus.up_ready_out), 1);

        // Single-flit vectors
        bus.up_ready_in = 1'b1;
        for (int v = 0; v < 9; v++) begin
            clear_logs();
            d0 = int'(bus.drop_count);
            if (vecs[v].from_dn) dn_q.push_back(vecs[v].data);
            else                 ni_q.push_back(vecs[v].data);
            repeat (6) step();
            chk($sformatf("vec%0d_ej_n", v), 32'(ej_log.size()), 32'(vecs[v].exp_ej));
            chk($sformatf("vec%0d_up_n", v), 32'(up_log.size()), 32'(vecs[v].exp_up));
            chk($sformatf("vec%0d_drops", v), 32'(int'(bus.drop_count) - d0), 32'(vecs[v].exp_drop));
            if (vecs[v].exp_ej == 1 && ej_log.size() == 1) begin
                chk($sformatf("vec%0d_ej_data", v), 32'(ej_log[0]), 32'(vecs[v].data));
                chk($sformatf("vec%0d_ej_lat", v),
                    32'(ej_cyc[0] - (vecs[v].from_dn ? dn_send_cyc : ni_send_cyc)), 1);
            end
            if (vecs[v].exp_up == 1 && up_log.size() == 1) begin
                chk($sformatf("vec%0d_up_data", v), 32'(up_log[0]), 32'(vecs[v].data));
                chk($sformatf("vec%0d_up_lat", v), 32'(up_cyc[0] - ni_send_cyc), 1);
            end
        end

        // Uplink stall with three queued flits
        clear_logs();
        bus.up_ready_in = 1'b0;
        ni_q.push_back(16'h12AB); ni_q.push_back(16'h12AC); ni_q.push_back(16'h12AD);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (bus.up_valid_out) found = 1'b1;
        end
        chk("stall_valid_seen", 32'(found), 1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("stall%0d_valid", k), 32'(bus.up_valid_out), 1);
            chk($sformatf("stall%0d_data", k), 32'(bus.up_data_out), 32'h12AB);
        end
        chk("stall_no_xfer", 32'(up_log.size()), 0);
        bus.up_ready_in = 1'b1;
        rel = cyc;
        repeat (6) step();
        chk("stall_xfer_n", 32'(up_log.size()), 3);
        for (int k = 0; k < 3 && k < up_log.size(); k++) begin
            chk($sformatf("stall_order%0d", k), 32'(up_log[k]), 32'h12AB + 32'(k));
            chk($sformatf("stall_cyc%0d", k), 32'(up_cyc[k]), 32'(rel + k));
        end

        // Ingress backpressure: 4 in the FIFO plus 1 in the uplink register
        clear_logs();
        bus.up_ready_in = 1'b0;
        for (int k = 0; k < 8; k++) ni_q.push_back(16'h2000 + 16'(k));
        repeat (20) step();
        chk("bp_ni_ready", 32'(bus.ni_ready_out), 0);
        chk("bp_taken", 32'(8 - ni_q.size()), 5);
        chk("bp_no_ovf", 32'(bus.err_overflow), 0);
        // Protocol violation while full: flit must be dropped and flagged
        d0 = int'(bus.drop_count);
        bus.ni_valid_in = 1'b1;
        bus.ni_data_in  = 16'hDC00;
        @(posedge clk); cyc++;
        @(negedge clk);
        bus.ni_valid_in = 1'b0;
        bus.ni_data_in  = '0;
        chk("ovf_flag", 32'(bus.err_overflow), 1);
        chk("ovf_drop", 32'(int'(bus.drop_count) - d0), 1);
        bus.up_ready_in = 1'b1;
        repeat (20) step();
        chk("bp_deliver_n", 32'(up_log.size()), 8);
        for (int k = 0; k < 8 && k < up_log.size(); k++)
            chk($sformatf("bp_order%0d", k), 32'(up_log[k]), 32'h2000 + 32'(k));

        // Invalid-header pop and misrouted downlink on the same edge
        clear_logs();
        d0 = int'(bus.drop_count);
        ni_q.push_back(16'h0007);
        step();
        chk("drop_pair_first", 32'(int'(bus.drop_count) - d0), 0);
        dn_q.push_back(16'h1000);
        step();
        chk("drop_pair_both", 32'(int'(bus.drop_count) - d0), 2);
        repeat (3) step();
        chk("drop_pair_no_ej", 32'(ej_log.size()), 0);
        chk("drop_pair_no_up", 32'(up_log.size()), 0);

        // Arbitration: both sides requesting continuously
        clear_logs();
        for (int k = 0; k < 8; k++) begin
            ni_q.push_back(16'h5100 + 16'(k));
            dn_q.push_back(16'h5200 + 16'(k));
        end
        repeat (40) step();
        chk("arb_n", 32'(ej_log.size()), 16);
        for (int k = 0; k < 16 && k < ej_log.size(); k++) begin
            chk($sformatf("arb_ord%0d", k), 32'(ej_log[k]),
                (k % 2 == 0) ? 32'h5200 + 32'(k / 2) : 32'h5100 + 32'(k / 2));
            chk($sformatf("arb_cyc%0d", k), 32'(ej_cyc[k] - ej_cyc[0]), 32'(k));
        end

        // Drop counter saturation
        for (int k = 0; k < 300; k++) dn_q.push_back(16'h1000);
        repeat (310) step();
        chk("drop_sat", 32'(bus.drop_count), 255);

        // Asynchronous reset with flits buffered
        clear_logs();
        bus.up_ready_in = 1'b0;
        ni_q.push_back(16'h3001); ni_q.push_back(16'h3002); ni_q.push_back(16'h3003);
        repeat (8) step();
        chk("pre_rst_up_valid", 32'(bus.up_valid_out), 1);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async");
        ni_q.delete();
        dn_q.delete();
        @(negedge clk);
        step();
        reset = 1'b1;
        bus.up_ready_in = 1'b1;
        clear_logs();
        repeat (10) step();
        chk("post_rst_no_ej", 32'(ej_log.size()), 0);
        chk("post_rst_no_up", 32'(up_log.size()), 0);
        chk("post_rst_drops", 32'(bus.drop_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
